sha256_mem_arbiter: RTL and testbench

//  Shares the single synchronous word memory port among NUM_REQ sha256 cores.

---
 rtl/sha256_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_sha256_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_mem_arbiter.sv
// Round-robin arbiter with burst lock that shares one synchronous word memory port
// among NUM_REQ sha256 cores; read data returns to the issuer two cycles after grant.
//   state     | meaning
//   ST_ARB    | round-robin search from rr_ptr, one access per cycle
//   ST_LOCKED | owner holds the port for a burst, other requesters wait
module sha256_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_clk,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               p0_vld_q, p0_vld_d, p1_vld_q, p1_vld_d;
  logic [IDX_W-1:0]   p0_id_q, p0_id_d, p1_id_q, p1_id_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   win;
  logic               grant_any;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) >= NUM_REQ - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  always_comb begin : rr_search
    int j;
    logic [IDX_W-1:0] cand;
    j     = 0;
    cand  = '0;
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    win       = pick;
    grant_any = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (found) begin
          grant_any = 1'b1;
          if (lock[pick]) begin
            state_d = ST_LOCKED;
            owner_d = pick;
          end else begin
            rr_ptr_d = next_idx(pick);
          end
        end
      end
      ST_LOCKED: begin
        win = owner_q;
        if (req[owner_q]) grant_any = 1'b1;
        if (!lock[owner_q]) begin
          state_d  = ST_ARB;
          rr_ptr_d = next_idx(owner_q);
        end
      end
      default: state_d = ST_ARB;
    endcase
    // A grant during the reset cycle would be silently dropped, so suppress it.
    if (!reset_n) grant_any = 1'b0;
  end

  always_comb begin : cmd_next
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_vld_d    = 1'b0;
    p0_id_d     = win;
    p1_vld_d    = p0_vld_q;
    p1_id_d     = p0_id_q;
    if (grant_any) begin
      mem_we_d    = we[win];
      mem_addr_d  = addr[win*ADDR_W +: ADDR_W];
      mem_wdata_d = wdata[win*DATA_W +: DATA_W];
      p0_vld_d    = ~we[win];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_vld_q    <= 1'b0;
      p0_id_q     <= '0;
      p1_vld_q    <= 1'b0;
      p1_id_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_vld_q    <= p0_vld_d;
      p0_id_q     <= p0_id_d;
      p1_vld_q    <= p1_vld_d;
      p1_id_q     <= p1_id_d;
    end
  end

  assign gnt            = grant_any ? (NUM_REQ'(1) << win) : '0;
  assign rvalid         = (reset_n && p1_vld_q) ? (NUM_REQ'(1) << p1_id_q) : '0;
  assign rdata          = (reset_n && p1_vld_q) ? mem_read_data : '0;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Self-checking bench for sha256_mem_arbiter: a 2-requester instance on a memory model
// with a read scoreboard, and a 3-requester instance for wrap-around arbitration.
module tb_sha256_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  req, lock, we;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wd, mem_rd;

  logic [2:0]  req3, lock3, we3;
  logic [47:0] addr3;
  logic [95:0] wdata3;
  logic [2:0]  gnt3, rvalid3;
  logic [31:0] rdata3;
  logic        mem_clk3, mem_we3;
  logic [15:0] mem_addr3;
  logic [31:0] mem_wd3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {int due; int id; logic [31:0] data;} rd_t;
  rd_t sb[$];

  sha256_mem_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_wd), .mem_read_data(mem_rd)
  );

  sha256_mem_arbiter #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(32)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .lock(lock3), .we(we3), .addr(addr3),
    .wdata(wdata3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .mem_clk(mem_clk3),
    .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_write_data(mem_wd3), .mem_read_data(32'h0)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {8'hA5, a, ~a, 8'h3C};
  endfunction

  // Synchronous memory: data for the registered address appears the following cycle.
  logic [31:0] mem [0:255];
  always @(posedge mem_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wd;
    end
    mem_rd <= mem[mem_addr[7:0]];
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    rd_t e;
    if (reset_n === 1'b1) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        total++; bad++;
        $display("FAIL rd_missing id=%0d due=%0d now=%0d", sb[0].id, sb[0].due, cyc);
        sb.delete(0);
      end
      if (rvalid !== 2'b00) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected rvalid=%b rdata=%h cyc=%0d", rvalid, rdata, cyc);
        end else begin
          e = sb.pop_front();
          if (rvalid !== (2'b01 << e.id) || rdata !== e.data || cyc != e.due) begin
            bad++;
            $display("FAIL rd_return got rvalid=%b rdata=%h cyc=%0d want id=%0d rdata=%h cyc=%0d",
                     rvalid, rdata, cyc, e.id, e.data, e.due);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input int id, input logic [31:0] data);
    rd_t e;
    e.due = cyc + 2; e.id = id; e.data = data;
    sb.push_back(e);
  endtask

  task automatic idle2();
    req = '0; lock = '0; we = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle2();
    req3 = '0; lock3 = '0; we3 = '0; addr3 = '0; wdata3 = '0; addr = '0; wdata = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({gnt, rvalid, rdata, mem_we, mem_addr, mem_wd} !== '0) begin
      bad++;
      $display("FAIL reset_outputs gnt=%b rvalid=%b rdata=%h we=%b addr=%h wd=%h want all 0",
               gnt, rvalid, rdata, mem_we, mem_addr, mem_wd);
    end
    tick();
  endtask

  task automatic test_reset_midburst();
    req = 2'b01; lock = 2'b01; we = 2'b00; addr[15:0] = 16'h0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (gnt !== 2'b01) begin bad++; $display("FAIL mid_gnt got=%b want=01", gnt); end
      tick();
      addr[15:0] = 16'h0011;
    end
    reset_n = 1'b0; idle2();
    @(negedge clk);
    total++;
    if (rvalid !== 2'b00 || gnt !== 2'b00) begin
      bad++; $display("FAIL mid_in_reset rvalid=%b gnt=%b want 00 00", rvalid, gnt);
    end
    tick(); tick();
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({gnt, rvalid, rdata, mem_we, mem_addr, mem_wd} !== '0) begin
      bad++;
      $display("FAIL mid_after_reset gnt=%b rvalid=%b rdata=%h we=%b addr=%h wd=%h want all 0",
               gnt, rvalid, rdata, mem_we, mem_addr, mem_wd);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      total++;
      if (rvalid !== 2'b00) begin bad++; $display("FAIL mid_dropped rvalid=%b want=00", rvalid); end
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    req = 2'b11; lock = 2'b00; we = 2'b00; addr = {16'h0030, 16'h0020};
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      total++;
      if (gnt !== exp) begin bad++; $display("FAIL rr_gnt step=%0d got=%b want=%b", k, gnt, exp); end
      push_rd(k % 2, init_word((k % 2 == 0) ? 8'h20 : 8'h30));
      tick();
    end
    idle2();
    repeat (3) tick();
  endtask

  task automatic test_burst();
    req = 2'b11; we = 2'b00; addr[31:16] = 16'h0050;
    for (int k = 0; k < 16; k++) begin
      addr[15:0] = 16'h0010 + 16'(k);
      lock = (k < 15) ? 2'b01 : 2'b00;
      @(negedge clk);
      total++;
      if (gnt !== 2'b01) begin bad++; $display("FAIL burst_gnt beat=%0d got=%b want=01", k, gnt); end
      push_rd(0, init_word(8'h10 + 8'(k)));
      tick();
    end
    req = 2'b10; lock = 2'b00;
    @(negedge clk);
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL burst_handoff got=%b want=10", gnt); end
    push_rd(1, init_word(8'h50));
    tick();
    idle2();
    repeat (3) tick();
  endtask

  task automatic test_write_read();
    req = 2'b10; we = 2'b10; lock = 2'b00; addr[31:16] = 16'h0040; wdata[63:32] = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL wr_gnt got=%b want=10", gnt); end
    tick();
    we = 2'b00;
    @(negedge clk);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0040 || mem_wd !== 32'hDEADBEEF || gnt !== 2'b10) begin
      bad++;
      $display("FAIL wr_cmd we=%b addr=%h wd=%h gnt=%b want 1 0040 deadbeef 10",
               mem_we, mem_addr, mem_wd, gnt);
    end
    push_rd(1, 32'hDEADBEEF);
    tick();
    idle2();
    @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 16'h0040) begin
      bad++; $display("FAIL rd_cmd we=%b addr=%h want 0 0040", mem_we, mem_addr);
    end
    repeat (3) tick();
  endtask

  task automatic test_idle_hold();
    req = 2'b01; lock = 2'b01; we = 2'b00; addr = {16'h0060, 16'h0012};
    @(negedge clk);
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL hold_first got=%b want=01", gnt); end
    push_rd(0, init_word(8'h12));
    tick();
    req = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (gnt !== 2'b00) begin bad++; $display("FAIL hold_idle cyc=%0d got=%b want=00", k, gnt); end
      tick();
    end
    lock = 2'b00;
    @(negedge clk);
    total++;
    if (gnt !== 2'b00) begin bad++; $display("FAIL hold_release got=%b want=00", gnt); end
    tick();
    @(negedge clk);
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL hold_next got=%b want=10", gnt); end
    push_rd(1, init_word(8'h60));
    tick();
    idle2();
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    logic [2:0] rq [5];
    logic [2:0] ex [5];
    rq[0] = 3'b010; ex[0] = 3'b010;
    rq[1] = 3'b011; ex[1] = 3'b001;
    rq[2] = 3'b011; ex[2] = 3'b010;
    rq[3] = 3'b111; ex[3] = 3'b100;
    rq[4] = 3'b111; ex[4] = 3'b001;
    we3 = 3'b111; lock3 = 3'b000; addr3 = {16'h0302, 16'h0301, 16'h0300};
    for (int k = 0; k < 5; k++) begin
      req3 = rq[k];
      @(negedge clk);
      total++;
      if (gnt3 !== ex[k]) begin bad++; $display("FAIL wrap_gnt step=%0d got=%b want=%b", k, gnt3, ex[k]); end
      tick();
    end
    req3 = '0;
    @(negedge clk);
    total++;
    if (mem_addr3 !== 16'h0300 || rvalid3 !== 3'b000) begin
      bad++; $display("FAIL wrap_cmd addr=%h rvalid=%b want 0300 000", mem_addr3, rvalid3);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reset_midburst();
    test_round_robin();
    test_burst();
    test_write_read();
    test_idle_hold();
    test_wrap();
    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
